// File: rtl/prover_compute_v_lanedrain.sv
`default_nettype none
// ============================================================================
// Module   : prover_compute_v_lanedrain
// Purpose  : Buffers one field-element result per parallel lane and drains
//            the buffers round-robin onto a single valid/ready stream.
//            Counts results per lane and flags completion after N_ROUNDS.
// Revision : 1.0  initial release
// ============================================================================
module prover_compute_v_lanedrain #(
  parameter int N_PARALLEL = 4,
  parameter int WIDTH      = 61,
  parameter int N_ROUNDS   = 8
) (
  input  logic                                clk,
  input  logic                                rstb,
  input  logic                                restart,
  input  logic [N_PARALLEL-1:0]               en_in,
  input  logic [N_PARALLEL-1:0][WIDTH-1:0]    data_in,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [WIDTH-1:0]                    out_data,
  output logic [(N_PARALLEL>1 ? $clog2(N_PARALLEL) : 1)-1:0] out_lane,
  output logic [N_PARALLEL-1:0]               lane_busy,
  output logic                                overflow,
  output logic                                done
);

  localparam int c_LW = (N_PARALLEL > 1) ? $clog2(N_PARALLEL) : 1;
  localparam int c_CW = $clog2(N_ROUNDS + 1);

  logic [N_PARALLEL-1:0][WIDTH-1:0] r_buf;
  logic [N_PARALLEL-1:0]            r_pending;
  logic [N_PARALLEL-1:0]            r_full;
  logic [c_LW-1:0]                  r_ptr;
  logic                             r_out_valid;
  logic [WIDTH-1:0]                 r_out_data;
  logic [c_LW-1:0]                  r_out_lane;
  logic                             r_overflow;
  logic                             r_done;

  logic                             w_fire;
  logic                             w_free;
  logic                             w_grant_vld;
  logic [c_LW-1:0]                  w_grant;
  logic [N_PARALLEL-1:0]            w_take;
  logic [N_PARALLEL-1:0]            w_accept;
  logic                             w_drop;
  logic                             w_done_cond;

  assign w_fire = r_out_valid & out_ready;
  assign w_free = ~r_out_valid | w_fire;

  // Round-robin pick: first pending lane at or after the pointer, with wrap.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant     = '0;
    for (int k = N_PARALLEL - 1; k >= 0; k--) begin
      int idx;
      idx = int'(r_ptr) + k;
      if (idx >= N_PARALLEL) idx = idx - N_PARALLEL;
      if (r_pending[idx]) begin
        w_grant_vld = 1'b1;
        w_grant     = c_LW'(idx);
      end
    end
  end

  generate
    for (genvar i = 0; i < N_PARALLEL; i++) begin : g_lane
      logic [c_CW-1:0] r_cnt;

      assign w_take[i]   = w_free & w_grant_vld & (w_grant == c_LW'(i));
      assign r_full[i]   = (r_cnt == c_CW'(N_ROUNDS));
      // A full buffer may be reloaded only in the cycle it drains to the output.
      assign w_accept[i] = en_in[i] & ~r_full[i] & (~r_pending[i] | w_take[i]);

      // Lane round counter and pending flag.
      always_ff @(posedge clk) begin
        if (!rstb || restart) begin
          r_cnt        <= '0;
          r_pending[i] <= 1'b0;
        end else begin
          if (w_accept[i]) r_cnt <= r_cnt + c_CW'(1);
          r_pending[i] <= w_accept[i] | (r_pending[i] & ~w_take[i]);
        end
      end

      // Lane data buffer; contents are meaningless while not pending.
      always_ff @(posedge clk) begin
        if (rstb && !restart && w_accept[i]) r_buf[i] <= data_in[i];
      end
    end
  endgenerate

  assign w_drop      = |(en_in & ~w_accept);
  assign w_done_cond = (&r_full) & ~(|r_pending) & w_free;

  // Output register, arbitration pointer and sticky status flags.
  always_ff @(posedge clk) begin
    if (!rstb || restart) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_lane  <= '0;
      r_ptr       <= '0;
      r_overflow  <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      if (w_free) begin
        if (w_grant_vld) begin
          r_out_valid <= 1'b1;
          r_out_data  <= r_buf[w_grant];
          r_out_lane  <= w_grant;
          r_ptr       <= (w_grant == c_LW'(N_PARALLEL - 1)) ? '0 : w_grant + c_LW'(1);
        end else begin
          r_out_valid <= 1'b0;
        end
      end
      r_overflow <= r_overflow | w_drop;
      r_done     <= r_done | w_done_cond;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_lane  = r_out_lane;
  assign lane_busy = r_pending;
  assign overflow  = r_overflow;
  assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_prover_compute_v_lanedrain.sv
`default_nettype none
// ============================================================================
// Module   : tb_prover_compute_v_lanedrain
// Purpose  : Directed self-checking bench for prover_compute_v_lanedrain.
//            Main instance uses N_ROUNDS=8; a second instance with
//            N_ROUNDS=2 shares the stimulus for the completion scenario.
// Revision : 1.0  initial release
// ============================================================================
module tb_prover_compute_v_lanedrain;

  logic                clk = 1'b0;
  logic                rstb;
  logic                restart;
  logic [3:0]          en_in;
  logic [3:0][60:0]    data_in;
  logic                out_ready;

  logic                out_valid, overflow, done;
  logic [60:0]         out_data;
  logic [1:0]          out_lane;
  logic [3:0]          lane_busy;

  logic                out_valid2, overflow2, done2;
  logic [60:0]         out_data2;
  logic [1:0]          out_lane2;
  logic [3:0]          lane_busy2;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  prover_compute_v_lanedrain #(.N_PARALLEL(4), .WIDTH(61), .N_ROUNDS(8)) dut (
    .clk(clk), .rstb(rstb), .restart(restart), .en_in(en_in), .data_in(data_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_lane(out_lane), .lane_busy(lane_busy), .overflow(overflow), .done(done)
  );

  prover_compute_v_lanedrain #(.N_PARALLEL(4), .WIDTH(61), .N_ROUNDS(2)) dut2 (
    .clk(clk), .rstb(rstb), .restart(restart), .en_in(en_in), .data_in(data_in),
    .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
    .out_lane(out_lane2), .lane_busy(lane_busy2), .overflow(overflow2), .done(done2)
  );

  // Compare one observed value against its hand-computed expectation.
  task automatic check_vec(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs set afterwards are seen at the following edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_restart();
    restart = 1'b1;
    step();
    restart = 1'b0;
  endtask

  initial begin
    rstb = 1'b0; restart = 1'b0; en_in = '0; data_in = '0; out_ready = 1'b0;
    step(); step();

    // Reset state
    check_vec("rst_valid", out_valid, 0);
    check_vec("rst_data", out_data, 0);
    check_vec("rst_lane", out_lane, 0);
    check_vec("rst_busy", lane_busy, 0);
    check_vec("rst_ovf", overflow, 0);
    check_vec("rst_done", done, 0);
    rstb = 1'b1;
    step();

    // Single pulse on lane 2
    out_ready = 1'b1;
    en_in = 4'b0100; data_in[2] = 61'h5;
    step();
    en_in = '0;
    check_vec("sp_busy", lane_busy, 4'b0100);
    check_vec("sp_valid0", out_valid, 0);
    step();
    check_vec("sp_valid", out_valid, 1);
    check_vec("sp_lane", out_lane, 2);
    check_vec("sp_data", out_data, 5);
    check_vec("sp_busy0", lane_busy, 0);
    step();
    check_vec("sp_valid_end", out_valid, 0);

    // Four lanes together, drained in lane order from pointer 0
    do_restart();
    for (int i = 0; i < 4; i++) data_in[i] = 61'(10 + i);
    en_in = 4'b1111;
    step();
    en_in = '0;
    check_vec("all_busy", lane_busy, 4'b1111);
    for (int k = 0; k < 4; k++) begin
      step();
      check_vec("all_valid", out_valid, 1);
      check_vec("all_lane", out_lane, k);
      check_vec("all_data", out_data, 10 + k);
    end
    step();
    check_vec("all_valid_end", out_valid, 0);
    check_vec("all_ovf", overflow, 0);

    // Backpressure, one buffered follow-up, one dropped pulse
    do_restart();
    out_ready = 1'b0;
    en_in = 4'b0010; data_in[1] = 61'h7;
    step();
    en_in = '0;
    for (int k = 0; k < 5; k++) begin
      step();
      check_vec("bp_hold_valid", out_valid, 1);
      check_vec("bp_hold_data", out_data, 7);
    end
    en_in = 4'b0010; data_in[1] = 61'h9;
    step();
    check_vec("bp_busy1", lane_busy[1], 1);
    check_vec("bp_ovf0", overflow, 0);
    data_in[1] = 61'hA;
    step();
    en_in = '0;
    check_vec("bp_ovf1", overflow, 1);
    check_vec("bp_still7", out_data, 7);
    out_ready = 1'b1;
    step();
    check_vec("bp_second_valid", out_valid, 1);
    check_vec("bp_second_data", out_data, 9);
    check_vec("bp_busy_clear", lane_busy, 0);
    step();
    check_vec("bp_drained", out_valid, 0);
    check_vec("bp_ovf_sticky", overflow, 1);

    // Round robin: pointer is 2 after lane 1 grants, so lane 3 precedes lane 0
    en_in = 4'b1001; data_in[0] = 61'h20; data_in[3] = 61'h23;
    step();
    en_in = '0;
    step();
    check_vec("rr_first_lane", out_lane, 3);
    check_vec("rr_first_data", out_data, 61'h23);
    step();
    check_vec("rr_second_lane", out_lane, 0);
    check_vec("rr_second_data", out_data, 61'h20);
    step();
    check_vec("rr_end", out_valid, 0);

    // Completion on the N_ROUNDS=2 instance
    do_restart();
    check_vec("cmp_done0", done2, 0);
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 4; i++) data_in[i] = 61'(16 * (r + 3) + i);
      en_in = 4'b1111;
      step();
      en_in = '0;
      for (int k = 0; k < 4; k++) begin
        step();
        check_vec("cmp_lane", out_lane2, k);
        check_vec("cmp_data", out_data2, 16 * (r + 3) + k);
      end
      check_vec("cmp_done_pending", done2, 0);
      step();
    end
    step();
    check_vec("cmp_done1", done2, 1);
    check_vec("cmp_ovf0", overflow2, 0);
    en_in = 4'b0001; data_in[0] = 61'h99;
    step();
    en_in = '0;
    step();
    check_vec("cmp_late_ovf", overflow2, 1);
    check_vec("cmp_late_novalid", out_valid2, 0);
    check_vec("cmp_done_sticky", done2, 1);
    do_restart();
    check_vec("cmp_rs_done", done2, 0);
    check_vec("cmp_rs_ovf", overflow2, 0);
    en_in = 4'b0100; data_in[2] = 61'h55;
    step();
    en_in = '0;
    step();
    check_vec("cmp_rs_valid", out_valid2, 1);
    check_vec("cmp_rs_lane", out_lane2, 2);
    check_vec("cmp_rs_data", out_data2, 61'h55);
    step();

    // Reset while streaming with three lanes still pending
    do_restart();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) data_in[i] = 61'(64 + i);
    en_in = 4'b1111;
    step();
    en_in = '0;
    step();
    check_vec("mr_valid_pre", out_valid, 1);
    check_vec("mr_busy_pre", lane_busy, 4'b1110);
    rstb = 1'b0;
    step();
    check_vec("mr_valid", out_valid, 0);
    check_vec("mr_data", out_data, 0);
    check_vec("mr_lane", out_lane, 0);
    check_vec("mr_busy", lane_busy, 0);
    check_vec("mr_ovf", overflow, 0);
    check_vec("mr_done", done, 0);
    rstb = 1'b1; out_ready = 1'b1;
    en_in = 4'b1000; data_in[3] = 61'h77;
    step();
    en_in = '0;
    step();
    check_vec("mr_new_valid", out_valid, 1);
    check_vec("mr_new_lane", out_lane, 3);
    check_vec("mr_new_data", out_data, 61'h77);
    step();
    check_vec("mr_new_end", out_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
